// File: rtl/tf_rd_check_pkg.sv
// tf_check_pkg: types and defaults shared by the TF-card read-data checker.
//   state_t        checker FSM states (IDLE, CHECK, DONE)
//   DATA_W         default read-data width
//   WORDS_PER_SEC  default words per sector (512 bytes / 2)
//   SEED           default expected value of the first word of each sector
//   TIMEOUT_CYC    default inter-word idle limit (timeout build only)
//   ERR_CNT_MAX    saturation value of the error counter
//   sat_inc()      saturating increment of the error counter
package tf_check_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int          DATA_W        = 16;
  localparam int          WORDS_PER_SEC = 256;
  localparam logic [15:0] SEED          = 16'h0000;
  localparam logic [23:0] TIMEOUT_CYC   = 24'd10_000_000;
  localparam logic [15:0] ERR_CNT_MAX   = 16'hFFFF;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == ERR_CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/tf_rd_check_if.sv
// tf_rd_check_if: handshake bundle between the sector read controller
// (master) and the read-data checker (slave).
//   start       single-cycle pulse, begin checking one sector
//   rd_en       read-data valid strobe
//   rd_data     read data word, qualified by rd_en
//   clr         synchronous clear of error_flag / err_cnt
//   busy        checker is in CHECK or DONE
//   done        single-cycle end-of-sector pulse
//   error_flag  sticky mismatch indication (LED alarm)
//   err_cnt     saturating count of mismatching words
interface tf_rd_check_if #(
  parameter int DATA_W = tf_check_pkg::DATA_W
) ();

  logic              start;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              clr;
  logic              busy;
  logic              done;
  logic              error_flag;
  logic [15:0]       err_cnt;

  modport master (
    output start, rd_en, rd_data, clr,
    input  busy, done, error_flag, err_cnt
  );

  modport slave (
    input  start, rd_en, rd_data, clr,
    output busy, done, error_flag, err_cnt
  );

endinterface

// File: rtl/tf_rd_check_gap_wdt.sv
// tf_gap_wdt: inter-word gap watchdog for the read-data checker.
//   clk, rst_n  clock, asynchronous active-low reset
//   en          high while the checker is in CHECK; low holds the count at 0
//   kick        read-data strobe; restarts the gap count
//   expire      combinational: this cycle ends the allowed idle window
// The count clears on kick and whenever en is low, so entry into CHECK
// always starts from zero. expire is raised in the cycle whose clock edge
// would take the count to TIMEOUT_CYC-1, so the caller acts on that same
// edge: with TIMEOUT_CYC = N the action lands N cycles after the last
// kick cycle. A kick in the same cycle suppresses expire.
module tf_gap_wdt #(
  parameter logic [23:0] TIMEOUT_CYC = tf_check_pkg::TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic kick,
  output logic expire
);

  logic [23:0] gap_q;
  logic [23:0] gap_next;

  assign gap_next = gap_q + 24'd1;
  assign expire   = en && !kick && (gap_next == TIMEOUT_CYC - 24'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q <= '0;
    end else if (!en || kick) begin
      gap_q <= '0;
    end else if (!expire) begin
      gap_q <= gap_next;
    end
  end

endmodule

// File: rtl/tf_rd_check.sv
// tf_rd_check: checks each TF-card sector read stream against an
// incrementing pattern starting at SEED.
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         tf_rd_check_if.slave: start/rd_en/rd_data/clr in,
//               busy/done/error_flag/err_cnt out
// Optional build macro TF_CHECK_TIMEOUT_EN: adds the TIMEOUT_CYC parameter
// and a gap watchdog that ends the sector with an error when no word
// arrives within TIMEOUT_CYC cycles.
// error_flag and err_cnt are sticky across sectors; only clr or reset
// clears them, and a mismatch in the same cycle as clr wins (count = 1).
module tf_rd_check #(
`ifdef TF_CHECK_TIMEOUT_EN
  parameter logic [23:0] TIMEOUT_CYC   = tf_check_pkg::TIMEOUT_CYC,
`endif
  parameter int          DATA_W        = tf_check_pkg::DATA_W,
  parameter int          WORDS_PER_SEC = tf_check_pkg::WORDS_PER_SEC,
  parameter logic [DATA_W-1:0] SEED    = DATA_W'(tf_check_pkg::SEED)
) (
  input  logic           clk,
  input  logic           rst_n,
  tf_rd_check_if.slave   bus
);

  import tf_check_pkg::*;

  localparam int             CNT_W    = $clog2(WORDS_PER_SEC);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS_PER_SEC - 1);

  state_t            state_q;
  state_t            state_d;
  logic [DATA_W-1:0] expected_q;
  logic [CNT_W-1:0]  word_cnt_q;
  logic              error_flag_q;
  logic [15:0]       err_cnt_q;

  logic              accept;
  logic              mismatch;
  logic              expire;
  logic              err_evt;

  // Words are only consumed in CHECK; rd_en in IDLE (including the start
  // cycle) or DONE is dropped.
  assign accept   = (state_q == CHECK) && bus.rd_en;
  assign mismatch = accept && (bus.rd_data != expected_q);

`ifdef TF_CHECK_TIMEOUT_EN
  tf_gap_wdt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_gap_wdt (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (state_q == CHECK),
    .kick   (bus.rd_en),
    .expire (expire)
  );
`else
  assign expire = 1'b0;
`endif

  // A timeout and a word never coincide: the watchdog masks expire on kick.
  assign err_evt = mismatch || expire;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: the default assignment first keeps this combinational block from
  // inferring a latch on paths that do not change state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = CHECK;
      CHECK:   if ((accept && (word_cnt_q == LAST_IDX)) || expire) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q != IDLE);
    bus.done = (state_q == DONE);
  end

  // Pattern tracker: re-seeded on IDLE->CHECK, advanced per accepted word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expected_q <= SEED;
      word_cnt_q <= '0;
    end else if ((state_q == IDLE) && bus.start) begin
      expected_q <= SEED;
      word_cnt_q <= '0;
    end else if (accept) begin
      expected_q <= expected_q + DATA_W'(1);
      word_cnt_q <= word_cnt_q + CNT_W'(1);
    end
  end

  // Sticky error state; an error event overrides a coincident clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_flag_q <= 1'b0;
      err_cnt_q    <= '0;
    end else if (err_evt) begin
      error_flag_q <= 1'b1;
      err_cnt_q    <= bus.clr ? 16'd1 : sat_inc(err_cnt_q);
    end else if (bus.clr) begin
      error_flag_q <= 1'b0;
      err_cnt_q    <= '0;
    end
  end

  assign bus.error_flag = error_flag_q;
  assign bus.err_cnt    = err_cnt_q;

endmodule

// File: doc/tf_rd_check.md
Name: tf_rd_check

Overview:
- Read-data pattern checker for the TF-card test path.
- Sits between the TF-card sector read controller and the LED alarm stage.
- Compares each sector's read stream against an incrementing pattern.
- Drives a sticky error_flag, a saturating error count and a per-sector done pulse; error_flag feeds the alarm LED directly.

Parameters:
- DATA_W, 16: width of the read data word.
- WORDS_PER_SEC, 256: words per sector (512 bytes / 2).
- SEED, 16'h0000: expected value of the first word of every sector.
- TIMEOUT_CYC, 24'd10_000_000: maximum idle cycles between words in CHECK. Used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle pulse; begins checking one sector
- rd_en  in  1  read-data valid strobe from the read controller
- rd_data  in  DATA_W  read data word, qualified by rd_en
- clr  in  1  synchronous clear of error_flag and err_cnt
- busy  out  1  high while in CHECK or DONE
- done  out  1  single-cycle pulse at end of sector
- error_flag  out  1  sticky mismatch indication, to the LED alarm
- err_cnt  out  16  number of mismatching words, saturating

Behaviour:
- Reset values: FSM = IDLE; busy = 0, done = 0, error_flag = 0, err_cnt = 0; expected = SEED, word_cnt = 0.
- FSM states: IDLE, CHECK, DONE.
  - IDLE -> CHECK on start. On entry, expected <= SEED and word_cnt <= 0.
  - CHECK -> DONE on the rd_en that hits word_cnt == WORDS_PER_SEC-1.
  - DONE -> IDLE unconditionally after 1 cycle. done = 1 only in DONE.
- In CHECK, each rd_en cycle:
  - Compare rd_data against expected.
  - expected <= expected + 1, wrapping modulo 2^DATA_W.
  - word_cnt <= word_cnt + 1.
- On mismatch:
  - error_flag <= 1, visible the cycle after the offending rd_en.
  - err_cnt <= err_cnt + 1, saturating at 16'hFFFF.
- Latency: the last word's rd_en to done = 1 cycle. error_flag and err_cnt of the last word are valid in the same cycle as done.
- Boundary conditions:
  - error_flag and err_cnt persist across sectors. They clear only on clr or reset.
  - clr in the same cycle as a mismatch: the set wins. error_flag = 1 and err_cnt = 1 the next cycle.
  - start while busy is ignored.
  - rd_en in IDLE or DONE is ignored: no compare, no count.
  - start and rd_en in the same cycle in IDLE: only start is acted on; that word is not checked.
  - rd_en may be non-contiguous; gaps hold all state.
  - Reset mid-sector returns everything to reset values immediately (asynchronous).
- Width: word_cnt is $clog2(WORDS_PER_SEC) bits.

Optional Feature:
- Macro: TF_CHECK_TIMEOUT_EN.
- With the macro defined:
  - A gap counter runs in CHECK. It clears on every rd_en and on entry to CHECK.
  - When it reaches TIMEOUT_CYC-1 without an rd_en: error_flag <= 1, err_cnt += 1 (saturating), FSM -> DONE, so done pulses.
  - A timeout in the same cycle as an rd_en is suppressed; the rd_en wins.
- Without the macro: no gap counter. CHECK waits indefinitely for words.

Decomposition:
- Package tf_check_pkg holds:
  - the FSM state enum (IDLE, CHECK, DONE);
  - default constants DATA_W, WORDS_PER_SEC, SEED, TIMEOUT_CYC;
  - ERR_CNT_MAX = 16'hFFFF.
- One natural sub-module, tf_gap_wdt: the timeout gap counter with inputs en, kick and outputs expire. It is instantiated only under TF_CHECK_TIMEOUT_EN.

Test Plan:
- Clean sector: start, then 256 contiguous rd_en with data 0x0000..0x00FF -> done pulses 1 cycle after word 255; error_flag = 0, err_cnt = 0.
- Single corruption: as above, but word 10 = 0x1234 -> error_flag = 1 from the cycle after word 10, stays 1 after done; err_cnt = 1.
- Stickiness and clr: two sectors, one error in each -> err_cnt = 2. Pulse clr -> error_flag = 0, err_cnt = 0. clr coincident with a mismatch -> err_cnt = 1, error_flag = 1.
- Gaps and ignores:
  - rd_en with 3 idle cycles between words -> clean result.
  - rd_en in IDLE with data 0xFFFF -> no error.
  - start during CHECK -> word_cnt is not reset.
- Saturation: force err_cnt to 16'hFFFE, then feed 3 bad words -> err_cnt stays 16'hFFFF.
- Timeout (macro on, TIMEOUT_CYC = 100): start, 5 good words, then silence -> done and error_flag = 1 exactly 100 cycles after the last rd_en, err_cnt = 1. Mid-sector rst_n low -> all outputs 0 immediately.
